// File: rtl/cordic_vectoring_core.sv
// Iterative CORDIC vectoring engine: rotates (x, y) onto the +x axis one micro-rotation per clock,
// returning the gain-scaled magnitude and the accumulated phase as a signed binary angle.
//
// state | meaning
// IDLE  | waiting for start; inputs pre-rotated into the right half-plane on acceptance
// ITER  | one micro-rotation per cycle, counter i = 0..ITERATIONS-1
// DONE  | one-cycle done pulse; magnitude/angle were registered on entry
module cordic_vectoring_core #(
    parameter int WORD_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int ITERATIONS  = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [WORD_WIDTH-1:0]  x_in,
    input  logic signed [WORD_WIDTH-1:0]  y_in,
    output logic                          busy,
    output logic                          done,
    output logic signed [WORD_WIDTH+1:0]  magnitude,
    output logic signed [ANGLE_WIDTH-1:0] angle
);

    localparam int XW = WORD_WIDTH + 2;
    localparam int CW = $clog2(ITERATIONS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);
    localparam logic signed [ANGLE_WIDTH-1:0] QUARTER     = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};
    localparam logic signed [ANGLE_WIDTH-1:0] NEG_QUARTER = {2'b11, {(ANGLE_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [XW-1:0]          x_q, x_d, y_q, y_d;
    logic signed [ANGLE_WIDTH-1:0] z_q, z_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          zero_q, zero_d;
    logic signed [XW-1:0]          mag_q, mag_d;
    logic signed [ANGLE_WIDTH-1:0] ang_q, ang_d;

    logic signed [XW-1:0]          x_ext, y_ext;
    logic signed [XW-1:0]          x_sh, y_sh, x_rot, y_rot;
    logic signed [ANGLE_WIDTH-1:0] atan_i, z_rot;

    // arctan(2^-i) in binary-angle units, rescaled for angle widths other than 16
    function automatic logic signed [ANGLE_WIDTH-1:0] atan_lut(input int idx);
        int base;
        case (idx)
            0:       base = 8192;
            1:       base = 4836;
            2:       base = 2555;
            3:       base = 1297;
            4:       base = 651;
            5:       base = 326;
            6:       base = 163;
            7:       base = 81;
            8:       base = 41;
            9:       base = 20;
            10:      base = 10;
            11:      base = 5;
            default: base = 0;
        endcase
        if (ANGLE_WIDTH >= 16) begin
            return ANGLE_WIDTH'(base <<< (ANGLE_WIDTH - 16));
        end else begin
            return ANGLE_WIDTH'(base >>> (16 - ANGLE_WIDTH));
        end
    endfunction

    // widen before any negation so the most negative input negates cleanly
    assign x_ext = {{2{x_in[WORD_WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WORD_WIDTH-1]}}, y_in};

    always_comb begin
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_i = atan_lut(int'(cnt_q));
        if (y_q[XW-1]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_i;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_i;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    if (!x_in[WORD_WIDTH-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_in[WORD_WIDTH-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = QUARTER;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = NEG_QUARTER;
                    end
                end
            end
            ITER: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    mag_d   = zero_q ? '0 : x_rot;
                    ang_d   = zero_q ? '0 : z_rot;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
        end
    end

    assign busy      = (state_q == ITER);
    assign done      = (state_q == DONE);
    assign magnitude = mag_q;
    assign angle     = ang_q;

endmodule

// File: tb/tb_cordic_vectoring_core.sv
// Self-checking bench: an ideal-geometry model (K*|v|, atan2) with tolerances, checked every cycle,
// plus hand-computed literal expectations for the directed vectors.
module tb_cordic_vectoring_core;

    localparam int  N  = 12;
    localparam real K  = 1.6467602581;
    localparam real PI = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic               busy, done;
    logic signed [17:0] magnitude;
    logic signed [15:0] angle;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_vectoring_core #(.WORD_WIDTH(16), .ANGLE_WIDTH(16), .ITERATIONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .magnitude(magnitude), .angle(angle)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input real act, input real exp, input real tol);
        real d;
        n_checks++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0.1f, expected %0.1f +/- %0.1f", nm, act, exp, tol);
        end
    endtask

    task automatic chk_ang(input string nm, input real act, input real exp, input real tol);
        real d;
        n_checks++;
        d = act - exp;
        while (d >= 32768.0) d -= 65536.0;
        while (d < -32768.0) d += 65536.0;
        if (d < 0.0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0.1f, expected %0.1f +/- %0.1f (mod 65536)", nm, act, exp, tol);
        end
    endtask

    // ideal result of vectoring (x, y): K*|v| and atan2 in binary-angle units
    task automatic model_calc(input int x, input int y, output real mag, output real ang,
                              output real mtol, output real atol);
        if (x == 0 && y == 0) begin
            mag = 0.0; ang = 0.0; mtol = 0.0; atol = 0.0;
        end else begin
            mag  = K * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            ang  = $atan2(real'(y), real'(x)) * 32768.0 / PI;
            mtol = 4.0 + mag / 8000.0;
            atol = 12.0 + 8000.0 / mag;
        end
    endtask

    bit  m_active = 1'b0;
    int  m_d = 0;
    real pend_mag = 0.0, pend_ang = 0.0, pend_mtol = 0.0, pend_atol = 0.0;
    real held_mag = 0.0, held_ang = 0.0, held_mtol = 0.0, held_atol = 0.0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_d = 0;
            held_mag = 0.0; held_ang = 0.0; held_mtol = 0.0; held_atol = 0.0;
        end else if (m_active) begin
            m_d++;
            if (m_d == N) begin
                held_mag = pend_mag; held_ang = pend_ang;
                held_mtol = pend_mtol; held_atol = pend_atol;
            end
            if (m_d == N + 1) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_d = 0;
            model_calc(int'(x_in), int'(y_in), pend_mag, pend_ang, pend_mtol, pend_atol);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_eq("rst_busy", longint'(busy), 0);
            chk_eq("rst_done", longint'(done), 0);
            chk_eq("rst_mag", longint'(magnitude), 0);
            chk_eq("rst_ang", longint'(angle), 0);
        end else begin
            chk_eq("busy", longint'(busy), longint'(m_active && m_d <= N - 1));
            chk_eq("done", longint'(done), longint'(m_active && m_d == N));
            chk_near("mag", real'(magnitude), held_mag, held_mtol);
            chk_ang("ang", real'(angle), held_ang, held_atol);
        end
    end

    // returns at the negedge where done is seen; lat counts cycles with the start cycle as 1
    task automatic run_op(input int x, input int y, output int lat);
        @(negedge clk);
        x_in = 16'(x); y_in = 16'(y); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: no done within %0d cycles for (%0d,%0d)", lat, x, y);
        end
    endtask

    typedef struct { int x; int y; } vec_t;
    vec_t extra[5] = '{'{3000, -4000}, '{-20000, 12345}, '{32767, -32768}, '{-7, -12000}, '{15000, 15000}};

    initial begin
        int lat;
        int ndone;

        repeat (3) @(negedge clk);
        chk_eq("reset_busy", longint'(busy), 0);
        chk_eq("reset_mag", longint'(magnitude), 0);
        #2 rst_n = 1'b1;

        run_op(1000, 0, lat);
        chk_eq("lat_1000_0", lat, 13);
        chk_near("mag_1000_0", real'(magnitude), 1647.0, 3.0);
        chk_ang("ang_1000_0", real'(angle), 0.0, 8.0);

        run_op(0, 1000, lat);
        chk_eq("lat_back_to_back", lat, 13);
        chk_near("mag_0_1000", real'(magnitude), 1647.0, 3.0);
        chk_ang("ang_0_1000", real'(angle), 16384.0, 8.0);

        run_op(-1000, -1000, lat);
        chk_near("mag_m1000_m1000", real'(magnitude), 2329.0, 4.0);
        chk_ang("ang_m1000_m1000", real'(angle), -24576.0, 8.0);

        run_op(-1000, 0, lat);
        chk_near("mag_m1000_0", real'(magnitude), 1647.0, 3.0);
        chk_ang("ang_m1000_0", real'(angle), -32768.0, 8.0);

        run_op(-32768, -32768, lat);
        chk_near("mag_full_scale", real'(magnitude), 76312.5, 8.0);
        chk_ang("ang_full_scale", real'(angle), -24576.0, 8.0);

        run_op(0, 0, lat);
        chk_eq("lat_zero", lat, 13);
        chk_eq("mag_zero", longint'(magnitude), 0);
        chk_eq("ang_zero", longint'(angle), 0);

        // start pulses at cycle 3 (busy) and cycle 13 (done) must both be dropped
        @(negedge clk);
        x_in = 16'sd3000; y_in = 16'sd4000; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 13);
            if (k == 3) begin
                x_in = -16'sd5000; y_in = 16'sd7;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        chk_eq("lat_ignored_starts", lat, 13);
        chk_near("mag_3000_4000", real'(magnitude), 8233.8, 6.0);
        chk_ang("ang_3000_4000", real'(angle), 9672.2, 12.0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("ignored_start_idle", longint'(busy), 0);

        // asynchronous reset five cycles into an operation
        @(negedge clk);
        x_in = 16'sd1000; y_in = 16'sd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_busy", longint'(busy), 0);
        chk_eq("async_rst_mag", longint'(magnitude), 0);
        chk_eq("async_rst_ang", longint'(angle), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk_eq("no_done_after_reset", ndone, 0);

        run_op(1000, 1000, lat);
        chk_eq("lat_after_reset", lat, 13);
        chk_near("mag_1000_1000", real'(magnitude), 2329.0, 5.0);
        chk_ang("ang_1000_1000", real'(angle), 8192.0, 10.0);

        foreach (extra[i]) run_op(extra[i].x, extra[i].y, lat);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
